// File: rtl/wb_pkg.sv
// wb_pkg: load-type codes, write-back FSM states and offset-width helper
package wb_pkg;
  typedef enum logic [2:0] {
    LT_W  = 3'd0,
    LT_H  = 3'd1,
    LT_HU = 3'd2,
    LT_B  = 3'd3,
    LT_BU = 3'd4,
    LT_WU = 3'd5,
    LT_D  = 3'd6
  } load_type_e;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    WAIT  = 2'd2
  } state_e;
  function automatic int off_w(int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/wb_stage_lx_if.sv
// wb_stage_lx_if: MEM handshake, memory response and register-file/hazard outputs of the write-back stage
//   master: drives m_* and dm_*; observes m_ready, rf_*, pend_*, exc_misalign, err_*
//   slave : the write-back stage itself
interface wb_stage_lx_if
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  localparam int OW = off_w(DATA_W);
  logic              m_valid;
  logic              m_ready;
  logic              m_is_load;
  logic [2:0]        m_load_type;
  logic [OW-1:0]     m_offset;
  logic              m_reg_we;
  logic [REG_AW-1:0] m_rd;
  logic [DATA_W-1:0] m_alu;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pend_valid;
  logic [REG_AW-1:0] pend_rd;
  logic              exc_misalign;
  logic              err_timeout;
  logic              err_spurious;
  modport master (
    output m_valid, m_is_load, m_load_type, m_offset, m_reg_we, m_rd, m_alu, dm_rvalid, dm_rdata,
    input  m_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd, exc_misalign, err_timeout, err_spurious
  );
  modport slave (
    input  m_valid, m_is_load, m_load_type, m_offset, m_reg_we, m_rd, m_alu, dm_rvalid, dm_rdata,
    output m_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd, exc_misalign, err_timeout, err_spurious
  );
endinterface

// File: rtl/wb_stage_lx_load_ext.sv
// load_ext: little-endian sub-word select, sign/zero extension and alignment check for loads
//   data_i raw memory word, offset_i low address bits, type_i load-type code
//   data_o extended result, misalign_o offset not a multiple of the access size
module load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]        data_i,
  input  logic [off_w(DATA_W)-1:0] offset_i,
  input  logic [2:0]               type_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     misalign_o
);
  logic [DATA_W-1:0] sh;
  logic signed [DATA_W-1:0] sb, shw, sw;
  logic [2:0] lt;
  logic byt, half, word;
  // 32-bit builds have no wider-than-word loads, so LWU/LD collapse to LW
  assign lt = (DATA_W == 32 && (type_i == LT_WU || type_i == LT_D)) ? LT_W : type_i;
  assign byt = lt == LT_B || lt == LT_BU;
  assign half = lt == LT_H || lt == LT_HU;
  assign word = lt == LT_W || lt == LT_WU;
  assign sh = data_i >> {offset_i, 3'b000};
  assign sb = $signed(sh[7:0]);
  assign shw = $signed(sh[15:0]);
  assign sw = $signed(sh[31:0]);
  // anything that is not byte/half/word (LD, undefined codes) is a full-width access
  assign misalign_o = byt ? 1'b0 : half ? offset_i[0] : word ? |offset_i[1:0] : |offset_i;
  assign data_o = lt == LT_B  ? sb :
                  lt == LT_BU ? DATA_W'(sh[7:0]) :
                  lt == LT_H  ? shw :
                  lt == LT_HU ? DATA_W'(sh[15:0]) :
                  lt == LT_W  ? sw :
                  lt == LT_WU ? DATA_W'(sh[31:0]) : data_i;
endmodule

// File: rtl/wb_stage_lx.sv
// wb_stage_lx: registered write-back stage with variable-latency load capture, misalignment and timeout detection
//   clk, reset (asynchronous, active-low)
//   bus (slave): m_* MEM handshake, dm_* load response, rf_* write/forwarding port,
//                pend_* waiting-load info, exc_misalign/err_timeout/err_spurious one-cycle pulses
module wb_stage_lx
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  wb_stage_lx_if.slave bus
);
  localparam int OW = off_w(DATA_W);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, pv_q, pv_d, pwe_q, pwe_d;
  logic exc_q, exc_d, tmo_q, tmo_d, spur_q, spur_d;
  logic [REG_AW-1:0] waddr_q, waddr_d, prd_q, prd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ext;
  logic [2:0] plt_q, plt_d;
  logic [OW-1:0] poff_q, poff_d;
  logic mis, waiting, accept;
  assign waiting = state_q == WAIT;
  assign accept = bus.m_valid && !waiting;
  // while waiting, the extender must use the parked load's type/offset, not whatever MEM presents
  load_ext #(.DATA_W(DATA_W)) u_ext (
    .data_i    (bus.dm_rdata),
    .offset_i  (waiting ? poff_q : bus.m_offset),
    .type_i    (waiting ? plt_q : bus.m_load_type),
    .data_o    (ext),
    .misalign_o(mis)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pv_d = pv_q;
    prd_d = prd_q;
    pwe_d = pwe_q;
    plt_d = plt_q;
    poff_d = poff_q;
    exc_d = 1'b0;
    tmo_d = 1'b0;
    spur_d = bus.dm_rvalid;
    if (waiting) begin
      if (bus.dm_rvalid) begin
        state_d = FULL;
        cnt_d = '0;
        we_d = pwe_q;
        waddr_d = prd_q;
        wdata_d = ext;
        pv_d = 1'b0;
        spur_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = EMPTY;
        cnt_d = '0;
        tmo_d = 1'b1;
        pv_d = 1'b0;
      end else cnt_d = cnt_q + CW'(1);
    end else if (accept) begin
      state_d = FULL;
      waddr_d = bus.m_rd;
      we_d = bus.m_reg_we && bus.m_rd != '0;
      if (!bus.m_is_load) wdata_d = bus.m_alu;
      else if (mis) begin
        we_d = 1'b0;
        exc_d = 1'b1;
      end else if (bus.dm_rvalid) begin
        wdata_d = ext;
        spur_d = 1'b0;
      end else begin
        state_d = WAIT;
        cnt_d = '0;
        we_d = 1'b0;
        pv_d = 1'b1;
        prd_d = bus.m_rd;
        pwe_d = bus.m_reg_we && bus.m_rd != '0;
        plt_d = bus.m_load_type;
        poff_d = bus.m_offset;
      end
    end else state_d = EMPTY;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= EMPTY;
      cnt_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pv_q <= 1'b0;
      prd_q <= '0;
      pwe_q <= 1'b0;
      plt_q <= '0;
      poff_q <= '0;
      exc_q <= 1'b0;
      tmo_q <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pv_q <= pv_d;
      prd_q <= prd_d;
      pwe_q <= pwe_d;
      plt_q <= plt_d;
      poff_q <= poff_d;
      exc_q <= exc_d;
      tmo_q <= tmo_d;
      spur_q <= spur_d;
    end
  // held low during reset so every output reads 0 while reset is asserted
  assign bus.m_ready = reset && !waiting;
  assign bus.rf_we = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.pend_valid = pv_q;
  assign bus.pend_rd = prd_q;
  assign bus.exc_misalign = exc_q;
  assign bus.err_timeout = tmo_q;
  assign bus.err_spurious = spur_q;
endmodule

// File: tb/tb_wb_stage_lx.sv
// tb_wb_stage_lx: directed and randomized checks of wb_stage_lx in 32-bit (TIMEOUT=4) and 64-bit builds
module tb_wb_stage_lx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic o_rdy, o_we, o_pv, o_exc, o_tmo, o_spur;
  logic [63:0] o_waddr, o_wdata, o_prd;
  wb_stage_lx_if #(.DATA_W(32), .REG_AW(5)) b32 ();
  wb_stage_lx_if #(.DATA_W(64), .REG_AW(5)) b64 ();
  wb_stage_lx #(.DATA_W(32), .REG_AW(5), .TIMEOUT(4)) u32 (.clk(clk), .reset(reset), .bus(b32));
  wb_stage_lx #(.DATA_W(64), .REG_AW(5), .TIMEOUT(16)) u64 (.clk(clk), .reset(reset), .bus(b64));
  always #5 clk = ~clk;
  // access size in bytes for a load type in a given build
  function automatic int ref_sz(int dw, int lt);
    if (lt == 3 || lt == 4) return 1;
    if (lt == 1 || lt == 2) return 2;
    if (lt == 0 || lt == 5 || dw == 32) return 4;
    return 8;
  endfunction
  function automatic logic [63:0] ref_ext(int dw, logic [63:0] d, int off, int lt);
    logic [63:0] m, v;
    int sz;
    logic sgn;
    sz = ref_sz(dw, lt);
    sgn = lt == 0 || lt == 1 || lt == 3 || (dw == 32 && lt >= 5);
    m = sz == 8 ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * sz)) - 64'd1;
    v = (d >> (8 * off)) & m;
    if (sgn && v[8*sz-1]) v = v | ~m;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(int dw, logic v, logic ld, int lt, int off, logic we, int rd, logic [63:0] alu, logic rv, logic [63:0] dat);
    b32.m_valid = v && dw == 32;
    b32.m_is_load = ld;
    b32.m_load_type = 3'(lt);
    b32.m_offset = 2'(off);
    b32.m_reg_we = we;
    b32.m_rd = 5'(rd);
    b32.m_alu = alu[31:0];
    b32.dm_rvalid = rv && dw == 32;
    b32.dm_rdata = dat[31:0];
    b64.m_valid = v && dw == 64;
    b64.m_is_load = ld;
    b64.m_load_type = 3'(lt);
    b64.m_offset = 3'(off);
    b64.m_reg_we = we;
    b64.m_rd = 5'(rd);
    b64.m_alu = alu;
    b64.dm_rvalid = rv && dw == 64;
    b64.dm_rdata = dat;
  endtask
  task automatic idle();
    drv(32, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic sample(int dw);
    o_rdy = dw == 32 ? b32.m_ready : b64.m_ready;
    o_we = dw == 32 ? b32.rf_we : b64.rf_we;
    o_waddr = dw == 32 ? 64'(b32.rf_waddr) : 64'(b64.rf_waddr);
    o_wdata = dw == 32 ? 64'(b32.rf_wdata) : b64.rf_wdata;
    o_pv = dw == 32 ? b32.pend_valid : b64.pend_valid;
    o_prd = dw == 32 ? 64'(b32.pend_rd) : 64'(b64.pend_rd);
    o_exc = dw == 32 ? b32.exc_misalign : b64.exc_misalign;
    o_tmo = dw == 32 ? b32.err_timeout : b64.err_timeout;
    o_spur = dw == 32 ? b32.err_spurious : b64.err_spurious;
  endtask
  task automatic chk_zero(string tag, int dw);
    sample(dw);
    chk({tag, "_rdy"}, 64'(o_rdy), 0);
    chk({tag, "_we"}, 64'(o_we), 0);
    chk({tag, "_waddr"}, o_waddr, 0);
    chk({tag, "_wdata"}, o_wdata, 0);
    chk({tag, "_pv"}, 64'(o_pv), 0);
    chk({tag, "_prd"}, o_prd, 0);
    chk({tag, "_exc"}, 64'(o_exc), 0);
    chk({tag, "_tmo"}, 64'(o_tmo), 0);
    chk({tag, "_spur"}, 64'(o_spur), 0);
  endtask
  int sw_lt[4] = '{3, 4, 1, 2};
  int sw_off[4] = '{3, 1, 2, 0};
  logic [63:0] sw_exp[4] = '{64'hFFFF_FF80, 64'h0000_007F, 64'hFFFF_80FF, 64'h0000_7F01};
  int d_lt[7] = '{5, 0, 6, 0, 3, 2, 6};
  int d_off[7] = '{0, 0, 0, 4, 7, 6, 4};
  logic [63:0] d_dat[7] = '{64'h0000_0000_F000_0000, 64'h0000_0000_F000_0000, 64'h0123_4567_89AB_CDEF,
                            64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                            64'h0123_4567_89AB_CDEF};
  logic [63:0] d_exp[7] = '{64'h0000_0000_F000_0000, 64'hFFFF_FFFF_F000_0000, 64'h0123_4567_89AB_CDEF,
                            64'h0000_0000_0123_4567, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0123, 64'h0};
  logic d_mis[7] = '{0, 0, 0, 0, 0, 0, 1};
  initial begin
    idle();
    #2 reset = 1'b0;
    #1;
    chk_zero("rst32", 32);
    chk_zero("rst64", 64);
    @(negedge clk);
    reset = 1'b1;
    #1;
    sample(32);
    chk("rst_release_rdy", 64'(o_rdy), 1);
    drv(32, 1, 0, 0, 0, 1, 5, 64'h1234_5678, 0, 0);
    tick();
    sample(32);
    chk("alu_we", 64'(o_we), 1);
    chk("alu_waddr", o_waddr, 5);
    chk("alu_wdata", o_wdata, 64'h1234_5678);
    chk("alu_rdy", 64'(o_rdy), 1);
    drv(32, 1, 0, 0, 0, 1, 6, 64'hA5A5_5A5A, 0, 0);
    tick();
    sample(32);
    chk("b2b_we", 64'(o_we), 1);
    chk("b2b_waddr", o_waddr, 6);
    chk("b2b_wdata", o_wdata, 64'hA5A5_5A5A);
    chk("b2b_rdy", 64'(o_rdy), 1);
    for (int i = 0; i < 4; i++) begin
      drv(32, 1, 1, sw_lt[i], sw_off[i], 1, 10 + i, 0, 1, 64'h80FF_7F01);
      tick();
      sample(32);
      chk("sub_we", 64'(o_we), 1);
      chk("sub_waddr", o_waddr, 64'(10 + i));
      chk("sub_wdata", o_wdata, sw_exp[i]);
      chk("sub_exc", 64'(o_exc), 0);
    end
    drv(32, 1, 1, 0, 0, 1, 9, 0, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      sample(32);
      chk("dly_pv", 64'(o_pv), 1);
      chk("dly_prd", o_prd, 9);
      chk("dly_rdy", 64'(o_rdy), 0);
      chk("dly_we", 64'(o_we), 0);
      if (i == 2) drv(32, 0, 0, 0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF);
      tick();
    end
    sample(32);
    chk("dly_done_we", 64'(o_we), 1);
    chk("dly_done_waddr", o_waddr, 9);
    chk("dly_done_wdata", o_wdata, 64'hDEAD_BEEF);
    chk("dly_done_pv", 64'(o_pv), 0);
    chk("dly_done_spur", 64'(o_spur), 0);
    idle();
    tick();
    sample(32);
    chk("idle_we", 64'(o_we), 0);
    drv(32, 1, 1, 0, 0, 1, 7, 0, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      sample(32);
      chk("tmo_wait_tmo", 64'(o_tmo), 0);
      chk("tmo_wait_rdy", 64'(o_rdy), 0);
      tick();
    end
    sample(32);
    chk("tmo_pulse", 64'(o_tmo), 1);
    chk("tmo_rdy", 64'(o_rdy), 1);
    chk("tmo_we", 64'(o_we), 0);
    chk("tmo_pv", 64'(o_pv), 0);
    tick();
    sample(32);
    chk("tmo_clear", 64'(o_tmo), 0);
    drv(32, 0, 0, 0, 0, 0, 0, 0, 1, 64'hCAFE_F00D);
    tick();
    sample(32);
    chk("spur_pulse", 64'(o_spur), 1);
    chk("spur_we", 64'(o_we), 0);
    idle();
    tick();
    sample(32);
    chk("spur_clear", 64'(o_spur), 0);
    drv(32, 1, 1, 0, 2, 1, 3, 0, 0, 0);
    tick();
    sample(32);
    chk("mis_lw_exc", 64'(o_exc), 1);
    chk("mis_lw_we", 64'(o_we), 0);
    chk("mis_lw_pv", 64'(o_pv), 0);
    chk("mis_lw_rdy", 64'(o_rdy), 1);
    drv(32, 1, 1, 1, 1, 1, 4, 0, 0, 0);
    tick();
    sample(32);
    chk("mis_lh_exc", 64'(o_exc), 1);
    chk("mis_lh_we", 64'(o_we), 0);
    drv(32, 1, 0, 0, 0, 1, 0, 64'h1111, 0, 0);
    tick();
    sample(32);
    chk("r0_we", 64'(o_we), 0);
    chk("r0_exc", 64'(o_exc), 0);
    chk("r0_rdy", 64'(o_rdy), 1);
    for (int p = 0; p < 2; p++) begin
      int dw;
      dw = p == 0 ? 32 : 64;
      for (int n = 0; n < 150; n++) begin
        logic ld, we, mis, wexp;
        int lt, off, rd, dly;
        logic [63:0] alu, dat;
        ld = 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
        lt = int'($urandom_range(0, 7));
        off = int'($urandom_range(0, dw / 8 - 1));
        rd = int'($urandom_range(0, 31));
        alu = {$urandom, $urandom};
        dat = {$urandom, $urandom};
        if (dw == 32) begin
          alu = alu & 64'hFFFF_FFFF;
          dat = dat & 64'hFFFF_FFFF;
        end
        mis = ld && (off % ref_sz(dw, lt)) != 0;
        dly = (ld && !mis) ? int'($urandom_range(0, 2)) : 0;
        wexp = we && rd != 0 && !mis;
        sample(dw);
        chk("rnd_rdy", 64'(o_rdy), 1);
        drv(dw, 1, ld, lt, off, we, rd, alu, ld && !mis && dly == 0, dat);
        tick();
        for (int k = 0; k < dly; k++) begin
          sample(dw);
          chk("rnd_pv", 64'(o_pv), 1);
          chk("rnd_prd", o_prd, 64'(rd));
          drv(dw, 0, 0, 0, 0, 0, 0, 0, k == dly - 1, dat);
          tick();
        end
        idle();
        sample(dw);
        chk("rnd_we", 64'(o_we), 64'(wexp));
        if (wexp) begin
          chk("rnd_waddr", o_waddr, 64'(rd));
          chk("rnd_wdata", o_wdata, ld ? ref_ext(dw, dat, off, lt) : alu);
        end
        chk("rnd_exc", 64'(o_exc), 64'(mis));
        chk("rnd_pv_end", 64'(o_pv), 0);
        chk("rnd_spur", 64'(o_spur), 0);
        chk("rnd_tmo", 64'(o_tmo), 0);
      end
    end
    drv(32, 1, 1, 0, 0, 1, 11, 0, 0, 0);
    tick();
    idle();
    sample(32);
    chk("rstw_pv", 64'(o_pv), 1);
    #2 reset = 1'b0;
    #1;
    chk_zero("rstw32", 32);
    @(negedge clk);
    reset = 1'b1;
    #1;
    sample(32);
    chk("rstw_rdy", 64'(o_rdy), 1);
    tick();
    sample(32);
    chk("rstw_tmo", 64'(o_tmo), 0);
    chk("rstw_spur", 64'(o_spur), 0);
    chk("rstw_pv_after", 64'(o_pv), 0);
    for (int i = 0; i < 7; i++) begin
      drv(64, 1, 1, d_lt[i], d_off[i], 1, 20 + i, 0, !d_mis[i], d_dat[i]);
      tick();
      sample(64);
      chk("d64_we", 64'(o_we), 64'(!d_mis[i]));
      chk("d64_exc", 64'(o_exc), 64'(d_mis[i]));
      if (!d_mis[i]) chk("d64_wdata", o_wdata, d_exp[i]);
    end
    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage_lx.md
Name: wb_stage_lx

Overview:
Registered write-back stage of the pipelined MIPS core, parametrised in data width. It accepts MEM-stage results through a valid/ready handshake and tolerates variable-latency load data from the data memory. It aligns and sign/zero-extends sub-word loads by address offset, then drives the register-file write port and the forwarding path. It also detects misaligned loads and stuck memory responses, which the single-cycle mux-only write-back could not do.

Parameters:
DATA_W, 32, datapath width; legal values are 32 or 64.
REG_AW, 5, register-file address width.
TIMEOUT, 16, maximum number of WAIT cycles before a load is aborted; must be at least 1.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
m_valid  in  1  MEM stage presents an instruction.
m_ready  out  1  stage can accept an instruction this cycle.
m_is_load  in  1  instruction is a load; selects memory data rather than ALU data.
m_load_type  in  3  load-type code, defined in wb_pkg.
m_offset  in  log2(DATA_W/8)  low address bits of the load.
m_reg_we  in  1  instruction writes the register file.
m_rd  in  REG_AW  destination register.
m_alu  in  DATA_W  ALU result.
dm_rvalid  in  1  memory read data is valid.
dm_rdata  in  DATA_W  raw memory word, little-endian.
rf_we  out  1  register-file write enable.
rf_waddr  out  REG_AW  register-file write address.
rf_wdata  out  DATA_W  register-file write data.
pend_valid  out  1  a load is waiting for data.
pend_rd  out  REG_AW  destination of the waiting load; used by the hazard unit to stall.
exc_misalign  out  1  one-cycle pulse: misaligned load.
err_timeout  out  1  one-cycle pulse: load aborted by timeout.
err_spurious  out  1  one-cycle pulse: dm_rvalid arrived with no load waiting.

Behaviour:
- Reset (asynchronous): state=EMPTY; all outputs are 0; the wait counter is 0.
- States:
  - EMPTY: no valid entry.
  - FULL: the entry is being written this cycle.
  - WAIT: a load is waiting for data.
- m_ready = (state != WAIT). A FULL entry always drains in one cycle.
- Accept condition: m_valid && m_ready.
- Transitions from EMPTY or FULL:
  - Accept of a non-load goes to FULL on the next cycle. rf_wdata=m_alu and rf_we = m_reg_we && (m_rd!=0).
  - Accept of a load with dm_rvalid in the same cycle goes to FULL. rf_wdata is the extended dm_rdata.
  - Accept of a load without dm_rvalid goes to WAIT, with counter=0 and pend_valid=1.
  - No accept goes to EMPTY with rf_we=0.
- Transitions from WAIT:
  - dm_rvalid goes to FULL with the extended data. The counter clears.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without data: err_timeout pulses, the state goes to EMPTY, and nothing is written. The aborted load's data is discarded if it arrives later and is flagged as spurious.
- Latency: 1 cycle from accept to rf_we when data is present. For a load, 1 cycle after the dm_rvalid cycle.
- Misalignment:
  - Word load with offset[1:0]!=0 is misaligned.
  - Half-word load with offset[0]!=0 is misaligned.
  - Double-word load (DATA_W=64) with offset!=0 is misaligned.
  - A misaligned load goes to FULL with rf_we forced to 0. exc_misalign pulses in that FULL cycle. The load never enters WAIT, and dm_rvalid is not expected for it.
- err_spurious pulses one cycle after dm_rvalid=1 in any cycle without an accepted-load or WAIT capture.
- Extension: a byte or half is selected at offset*8 bits, little-endian.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW sign-extends to DATA_W.
  - LWU and LD are legal only when DATA_W=64. In 32-bit builds they are treated as LW.
  - An undefined load-type code behaves as a full-width load.
- Registers: all outputs are registered. Writes to $0 never assert rf_we, but they still occupy FULL.
- Forwarding: rf_we, rf_waddr and rf_wdata are the forwarding source.
- Reset asserted mid-WAIT aborts immediately with no pulses.

Decomposition:
- Package wb_pkg holds:
  - load-type codes: LT_W=0, LT_H=1, LT_HU=2, LT_B=3, LT_BU=4, LT_WU=5, LT_D=6;
  - state encoding: EMPTY, FULL, WAIT;
  - a function returning the offset width from DATA_W.
- Sub-module load_ext: combinational, parametrised by DATA_W. It takes raw data, offset and type, and returns extended data plus a misaligned flag. It is instantiated once.

Test Plan:
- Non-load accept: m_alu=0x12345678, rd=5, we=1 -> next cycle rf_we=1, waddr=5, wdata=0x12345678. Back-to-back accepts keep m_ready=1 every cycle.
- Same-cycle sub-word loads on dm_rdata=0x80FF7F01:
  - LB, offset 3 -> 0xFFFFFF80.
  - LBU, offset 1 -> 0x0000007F.
  - LH, offset 2 -> 0xFFFF80FF.
  - LHU, offset 0 -> 0x00007F01.
- Delayed load: LW to rd=9; dm_rvalid arrives 3 cycles later with 0xDEADBEEF.
  - While waiting: pend_valid=1, pend_rd=9, m_ready=0.
  - One cycle after dm_rvalid: rf_we=1, wdata=0xDEADBEEF.
- Timeout with TIMEOUT=4: load accepted and no dm_rvalid arrives.
  - err_timeout pulses after 4 WAIT cycles; the state returns to EMPTY with no write.
  - A late dm_rvalid then raises err_spurious.
- Misaligned load: LW at offset 2 -> exc_misalign=1 and rf_we=0. LH at offset 1 -> the same response. A write to rd=0 -> rf_we=0.
- Reset and 64-bit build:
  - Assert reset during WAIT: all outputs go to 0 asynchronously. After release, m_ready=1.
  - With DATA_W=64: LWU on 0x00000000_F0000000 -> 0x00000000_F0000000.
